layer_generator: RTL and testbench



---
 rtl/layer_generator_pkg.sv | 20 ++
 rtl/lfsr16.sv | 24 ++
 rtl/layer_generator.sv | 150 +++++++++++++++
 tb/tb_layer_generator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/layer_generator_pkg.sv
// Shared types and constants for the platform row generator.
// Also holds the Galois LFSR step used by the random-event blocks.
package layer_generator_pkg;

    localparam int          LAYER_W    = 7;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [2:0]  PATH_START = 3'd3;
    localparam int          GEN_STEPS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        READY
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Reset and load both return it to the supplied seed.
module lfsr16
    import layer_generator_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/layer_generator.sv
// Builds the next platform row after each jump; every row keeps one
// safe cell adjacent to the previous one so the player can always land.
module layer_generator
    import layer_generator_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter int          LAYERS_PER_LEVEL = 16,
    parameter int          MAX_LEVEL        = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               module_en,
    input  logic               jump_left,
    input  logic               jump_right,
    output logic [0:LAYER_W-1] layer_map_out,
    output logic [0:LAYER_W-1] block_type_out,
    output logic               layer_ready,
    output logic [2:0]         level,
    output logic               jump_overrun
);

    localparam int CW = ($clog2(LAYERS_PER_LEVEL) < 4) ? 4
                      : $clog2(LAYERS_PER_LEVEL);

    state_t             state, state_nx;
    logic [1:0]         gen_cnt;
    logic [2:0]         path_col, path_nx;
    logic [CW-1:0]      layer_cnt;
    logic               counted;
    logic               build;
    logic               jump;
    logic [15:0]        lfsr_q;
    logic [15:0]        r;
    logic [0:LAYER_W-1] map_nx, type_nx;

    assign jump = jump_left | jump_right;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (!module_en),
        .seed  (LFSR_SEED),
        .step  (state == GEN),
        .state (lfsr_q)
    );

    // R is the value the LFSR takes on the fourth step edge
    assign r = lfsr_step(lfsr_q);

    always_comb begin
        path_nx = path_col;
        if (path_col == 3'd0) begin
            path_nx = 3'd1;
        end else if (path_col == 3'(LAYER_W - 1)) begin
            path_nx = path_col - 3'd1;
        end else if (r[7]) begin
            path_nx = path_col + 3'd1;
        end else begin
            path_nx = path_col - 3'd1;
        end
    end

    always_comb begin
        map_nx  = '0;
        type_nx = '0;
        for (int c = 0; c < LAYER_W; c++) begin
            if (c[0] == path_nx[0]) begin
                map_nx[c]  = r[c];
                type_nx[c] = r[c] & r[c+8] & (r[15:13] < level);
            end
        end
        map_nx[path_nx]  = 1'b1;
        type_nx[path_nx] = 1'b0;
    end

    always_comb begin
        state_nx = state;
        build    = 1'b0;
        unique case (state)
            IDLE: begin
                if (module_en) state_nx = GEN;
            end
            GEN: begin
                if (gen_cnt == 2'(GEN_STEPS - 1)) begin
                    state_nx = READY;
                    build    = 1'b1;
                end
            end
            READY: begin
                if (jump) state_nx = GEN;
            end
            default: state_nx = IDLE;
        endcase
        if (!module_en) begin
            state_nx = IDLE;
            build    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gen_cnt        <= '0;
            path_col       <= PATH_START;
            layer_cnt      <= '0;
            counted        <= 1'b0;
            layer_map_out  <= '0;
            block_type_out <= '0;
            layer_ready    <= 1'b0;
            level          <= '0;
            jump_overrun   <= 1'b0;
        end else if (!module_en) begin
            state          <= IDLE;
            gen_cnt        <= '0;
            path_col       <= PATH_START;
            layer_cnt      <= '0;
            counted        <= 1'b0;
            layer_map_out  <= '0;
            block_type_out <= '0;
            layer_ready    <= 1'b0;
            level          <= '0;
            jump_overrun   <= 1'b0;
        end else begin
            state   <= state_nx;
            gen_cnt <= (state == GEN) ? gen_cnt + 2'd1 : 2'd0;
            if (state == IDLE) counted <= 1'b0;
            if (jump && state != READY) jump_overrun <= 1'b1;
            if (state == READY && jump) begin
                layer_ready <= 1'b0;
                counted     <= 1'b1;
            end
            if (build) begin
                layer_map_out  <= map_nx;
                block_type_out <= type_nx;
                layer_ready    <= 1'b1;
                path_col       <= path_nx;
                // the first row after enable is not a climbed layer
                if (counted) begin
                    if (layer_cnt == CW'(LAYERS_PER_LEVEL - 1)) begin
                        layer_cnt <= '0;
                        if (level != 3'(MAX_LEVEL)) level <= level + 3'd1;
                    end else begin
                        layer_cnt <= layer_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_generator.sv
// Directed plus randomized bench for layer_generator.
// Expected rows come from an arithmetic model of the row rules.
module tb_layer_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       module_en;
    logic       jump_left;
    logic       jump_right;
    logic [0:6] layer_map_out;
    logic [0:6] block_type_out;
    logic       layer_ready;
    logic [2:0] level;
    logic       jump_overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_path;
    int          m_n;
    int          m_lvl;
    logic [0:6]  exp_map;
    logic [0:6]  exp_type;

    layer_generator dut (
        .clk            (clk),
        .rst            (rst),
        .module_en      (module_en),
        .jump_left      (jump_left),
        .jump_right     (jump_right),
        .layer_map_out  (layer_map_out),
        .block_type_out (block_type_out),
        .layer_ready    (layer_ready),
        .level          (level),
        .jump_overrun   (jump_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] next_rand(input logic [15:0] s);
        logic [15:0] v;
        v = s >> 1;
        if (s[0]) v = v ^ 16'hB400;
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr   = 16'hACE1;
        m_path   = 3;
        m_n      = 0;
        m_lvl    = 0;
        exp_map  = '0;
        exp_type = '0;
    endtask

    task automatic model_build(input bit from_jump);
        logic [15:0] r;
        int          lvl_used;
        for (int k = 0; k < 4; k++) m_lfsr = next_rand(m_lfsr);
        r = m_lfsr;
        if (m_path == 0)      m_path = 1;
        else if (m_path == 6) m_path = 5;
        else                  m_path = r[7] ? m_path + 1 : m_path - 1;
        lvl_used = m_lvl;
        for (int c = 0; c < 7; c++) begin
            if ((c % 2) == (m_path % 2)) begin
                exp_map[c]  = r[c];
                exp_type[c] = r[c] && r[c+8] && (int'(r[15:13]) < lvl_used);
            end else begin
                exp_map[c]  = 1'b0;
                exp_type[c] = 1'b0;
            end
        end
        exp_map[m_path]  = 1'b1;
        exp_type[m_path] = 1'b0;
        if (from_jump) begin
            m_n++;
            m_lvl = (m_n / 16 > 7) ? 7 : m_n / 16;
        end
    endtask

    task automatic wait_layer(input string tag);
        int k = 0;
        while (!layer_ready && k < 12) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_ready"}, layer_ready, 1);
        check({tag, "_map"}, layer_map_out, exp_map);
        check({tag, "_type"}, block_type_out, exp_type);
        check({tag, "_level"}, level, m_lvl);
        check({tag, "_type_wo_map"}, block_type_out & ~layer_map_out, 0);
    endtask

    task automatic do_jump(input bit l, input bit r, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        jump_left  = l;
        jump_right = r;
        @(posedge clk);
        #1;
        jump_left  = 1'b0;
        jump_right = 1'b0;
        check("jump_edge_ready", layer_ready, 0);
        check("jump_edge_hold", layer_map_out, exp_map);
    endtask

    initial begin
        logic [1:0] v;
        rst        = 1'b1;
        module_en  = 1'b0;
        jump_left  = 1'b0;
        jump_right = 1'b0;
        model_reset();
        #12;
        check("rst_map", layer_map_out, 0);
        check("rst_type", block_type_out, 0);
        check("rst_ready", layer_ready, 0);
        check("rst_level", level, 0);
        check("rst_overrun", jump_overrun, 0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        module_en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check("en_ready_low", layer_ready, 0);
            check("en_map_zero", layer_map_out, 0);
        end
        @(posedge clk);
        #1;
        model_build(1'b0);
        check("en_ready_edge5", layer_ready, 1);
        wait_layer("first");
        check("first_path_col", (layer_map_out[2] ^ layer_map_out[4]) |
              (exp_map[2] & exp_map[4]), 1);

        do_jump(1'b1, 1'b1, 0);
        model_build(1'b1);
        @(negedge clk);
        @(negedge clk);
        jump_left = 1'b1;
        @(posedge clk);
        #1;
        jump_left = 1'b0;
        check("overrun_set", jump_overrun, 1);
        wait_layer("dual");
        check("overrun_sticky", jump_overrun, 1);

        for (int i = 0; i < 999; i++) begin
            v = 2'($urandom_range(1, 3));
            do_jump(v[0], v[1], $urandom_range(0, 3));
            model_build(1'b1);
            wait_layer("ramp");
        end
        check("level_sat", level, 7);

        do_jump(1'b0, 1'b1, 1);
        @(negedge clk);
        module_en = 1'b0;
        @(posedge clk);
        #1;
        check("dis_map", layer_map_out, 0);
        check("dis_type", block_type_out, 0);
        check("dis_ready", layer_ready, 0);
        check("dis_level", level, 0);
        check("dis_overrun", jump_overrun, 0);

        model_reset();
        @(negedge clk);
        module_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        model_build(1'b0);
        check("reen_ready_edge5", layer_ready, 1);
        wait_layer("reen");

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_map", layer_map_out, 0);
        check("async_ready", layer_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        module_en = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
